// File: rtl/pool2x2_stream.sv
// 2x2 / stride-2 streaming pooling stage with register line buffer and row-gated video strobes.
// Define POOL_AVG_EN to compile in the run-time selectable average datapath; otherwise max only.
module pool2x2_stream #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24,
  parameter bit SIGNED = 1'b0
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic              cal_start,
  input  logic              pool_mode,
  input  logic [DATA_W-1:0] act_data,
  input  logic              act_data_vld,
  output logic [DATA_W-1:0] pool_data,
  output logic              pool_data_vld,
  output logic              pool_last,
  output logic              active_video,
  output logic              vid_hsync,
  output logic              vid_ce
);

  localparam int SW     = DATA_W + 2;
  localparam int HALF_W = IMG_W / 2;
  localparam int CW     = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW     = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LAW    = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
`ifdef POOL_AVG_EN
  localparam int LB_W = DATA_W + 1;
`else
  localparam int LB_W = DATA_W;
`endif

  if ((IMG_W < 2) || (IMG_H < 2) || ((IMG_W % 2) != 0) || ((IMG_H % 2) != 0)) begin : g_bad_geom
    $error("pool2x2_stream: IMG_W and IMG_H must be even and >= 2");
  end

`ifdef POOL_AVG_EN
  logic mode_q;
`else
  logic unused_mode;
  assign unused_mode = pool_mode;
`endif

  logic [CW-1:0]            col_cnt;
  logic [RW-1:0]            row_cnt;
  logic [LAW-1:0]           lb_idx;
  logic                     beat;
  logic signed [SW-1:0]     cur_x;
  logic signed [SW-1:0]     lb_rd;
  logic signed [SW-1:0]     win_red;
  logic [LB_W-1:0]          lbuf [HALF_W];
  logic signed [SW-1:0]     prev_p0;
  logic signed [SW-1:0]     part_p1;
  logic [DATA_W-1:0]        data_p1;
  logic                     vld_p1;
  logic                     last_p1;
  logic                     lastcol_p1;
  logic                     av_p1;

  function automatic logic signed [SW-1:0] ext_in(input logic [DATA_W-1:0] x);
    return {{2{SIGNED & x[DATA_W-1]}}, x};
  endfunction

  function automatic logic signed [SW-1:0] ext_lb(input logic [LB_W-1:0] x);
    return {{(SW-LB_W){SIGNED & x[LB_W-1]}}, x};
  endfunction

  // Operands are already extended per SIGNED, so a signed compare serves both modes.
  function automatic logic signed [SW-1:0] reduce2(input logic signed [SW-1:0] a,
                                                   input logic signed [SW-1:0] b);
`ifdef POOL_AVG_EN
    if (mode_q) return a + b;
`endif
    return (a >= b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] finalize(input logic signed [SW-1:0] s);
`ifdef POOL_AVG_EN
    logic signed [SW-1:0] q;
    if (mode_q) begin
      q = SIGNED ? (s >>> 2) : (s >> 2);
      return DATA_W'(q);
    end
`endif
    return DATA_W'(s);
  endfunction

  assign beat    = act_data_vld & ~cal_start;
  assign lb_idx  = LAW'(col_cnt >> 1);
  assign cur_x   = ext_in(act_data);
  assign lb_rd   = ext_lb(lbuf[lb_idx]);
  assign win_red = reduce2(part_p1, cur_x);

  // Stage p0/p1 datapath: top-row pair into line buffer, bottom-left into partial
  always_ff @(posedge sclk) begin
    if (cal_start) begin
      part_p1 <= '0;
    end else if (beat) begin
      if (!row_cnt[0] && !col_cnt[0]) prev_p0 <= cur_x;
      if (!row_cnt[0] &&  col_cnt[0]) lbuf[lb_idx] <= LB_W'(reduce2(prev_p0, cur_x));
      if ( row_cnt[0] && !col_cnt[0]) part_p1 <= reduce2(lb_rd, cur_x);
    end
  end

  // Stage p1 control: counters, output register and strobes
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      data_p1    <= '0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      lastcol_p1 <= 1'b0;
      av_p1      <= 1'b0;
`ifdef POOL_AVG_EN
      mode_q     <= 1'b0;
`endif
    end else if (cal_start) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      lastcol_p1 <= 1'b0;
      av_p1      <= 1'b0;
`ifdef POOL_AVG_EN
      mode_q     <= pool_mode;
`endif
    end else begin
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      lastcol_p1 <= 1'b0;
      if (vld_p1 && lastcol_p1) av_p1 <= 1'b0;
      if (act_data_vld) begin
        if (col_cnt == COL_LAST) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
        if (row_cnt[0] && (col_cnt == '0)) av_p1 <= 1'b1;
        if (row_cnt[0] && col_cnt[0]) begin
          data_p1    <= finalize(win_red);
          vld_p1     <= 1'b1;
          lastcol_p1 <= (col_cnt == COL_LAST);
          last_p1    <= (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);
        end
      end
    end
  end

  assign pool_data     = data_p1;
  assign pool_data_vld = vld_p1;
  assign pool_last     = last_p1;
  assign active_video  = av_p1;
  assign vid_hsync     = ~av_p1;
  assign vid_ce        = vld_p1 | ~av_p1;

endmodule
